// File: rtl/inst_cache_fill_pkg.sv
// Shared definitions for the instruction cache: FSM encoding and default geometry.
package inst_cache_fill_pkg;

    localparam int DEF_LINES = 16;
    localparam int DEF_WORDS = 4;
    localparam int OFF_W     = $clog2(DEF_WORDS);
    localparam int IDX_W     = $clog2(DEF_LINES);
    localparam int TAG_W     = 30 - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage: combinational read, synchronous word write and tag commit.
module inst_cache_array #(
    parameter int LINES    = 16,
    parameter int WORDS    = 4,
    parameter int IDX_BITS = 4,
    parameter int OFF_BITS = 2,
    parameter int TAG_BITS = 24
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic [IDX_BITS-1:0] rd_index,
    input  logic [OFF_BITS-1:0] rd_offset,
    output logic                rd_valid,
    output logic [TAG_BITS-1:0] rd_tag,
    output logic [31:0]         rd_data,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_index,
    input  logic [OFF_BITS-1:0] wr_offset,
    input  logic [31:0]         wr_data,
    input  logic                commit_en,
    input  logic [IDX_BITS-1:0] commit_index,
    input  logic [TAG_BITS-1:0] commit_tag,
    input  logic                commit_valid
);

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES*WORDS];

    // Flush wins over a same-cycle commit so fence.i never leaves a line valid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (commit_en) begin
            valid[commit_index] <= commit_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (commit_en) tag_mem[commit_index] <= commit_tag;
        if (wr_en) data_mem[{wr_index, wr_offset}] <= wr_data;
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/inst_cache_fill.sv
// Direct-mapped instruction cache: hit logic, miss/refill FSM and miss statistics.
module inst_cache_fill
    import inst_cache_fill_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      address,
    output logic [31:0]      outInst,
    output logic             hit,
    input  logic             flush,
    output logic             memReq,
    output logic [31:0]      memAddr,
    input  logic             memReady,
    input  logic [31:0]      memData,
    output logic [CNT_W-1:0] missCount
);

    localparam int OFF_BITS = $clog2(WORDS);
    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = 30 - OFF_BITS - IDX_BITS;

    state_t              state;
    logic [TAG_BITS-1:0] miss_tag;
    logic [IDX_BITS-1:0] miss_index;
    logic [OFF_BITS-1:0] fill_cnt;
    logic [OFF_BITS-1:0] fill_next;
    logic                flush_seen;
    logic                last_word;

    logic [OFF_BITS-1:0] a_off;
    logic [IDX_BITS-1:0] a_index;
    logic [TAG_BITS-1:0] a_tag;
    logic                unused_byte_bits;

    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    logic [31:0]         rd_data;

    assign a_off            = address[OFF_BITS+1:2];
    assign a_index          = address[OFF_BITS+IDX_BITS+1 -: IDX_BITS];
    assign a_tag            = address[31 -: TAG_BITS];
    assign unused_byte_bits = ^address[1:0];

    assign fill_next = fill_cnt + 1'b1;
    assign last_word = (fill_cnt == OFF_BITS'(WORDS - 1));

    assign hit     = (state == IDLE) && rd_valid && (rd_tag == a_tag) && !flush;
    assign outInst = hit ? rd_data : 32'h0;

    inst_cache_array #(
        .LINES    (LINES),
        .WORDS    (WORDS),
        .IDX_BITS (IDX_BITS),
        .OFF_BITS (OFF_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_array (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .rd_index     (a_index),
        .rd_offset    (a_off),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_data      (rd_data),
        .wr_en        ((state == FILL) && memReady),
        .wr_index     (miss_index),
        .wr_offset    (fill_cnt),
        .wr_data      (memData),
        .commit_en    (state == COMMIT),
        .commit_index (miss_index),
        .commit_tag   (miss_tag),
        .commit_valid (!flush_seen)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            memReq     <= 1'b0;
            memAddr    <= '0;
            fill_cnt   <= '0;
            missCount  <= '0;
            miss_tag   <= '0;
            miss_index <= '0;
            flush_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush && !hit) begin
                        miss_tag   <= a_tag;
                        miss_index <= a_index;
                        fill_cnt   <= '0;
                        flush_seen <= 1'b0;
                        if (missCount != {CNT_W{1'b1}}) missCount <= missCount + 1'b1;
                        memReq     <= 1'b1;
                        memAddr    <= {a_tag, a_index, {OFF_BITS{1'b0}}, 2'b00};
                        state      <= FILL;
                    end
                end
                FILL: begin
                    // A flush mid-refill lets the handshake finish but poisons the commit.
                    if (flush) flush_seen <= 1'b1;
                    if (memReady) begin
                        fill_cnt <= fill_next;
                        if (last_word) begin
                            memReq <= 1'b0;
                            state  <= COMMIT;
                        end else begin
                            memAddr <= {miss_tag, miss_index, fill_next, 2'b00};
                        end
                    end
                end
                COMMIT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_cache_fill.sv
// Directed bench for inst_cache_fill; backing memory returns address+0x100 for each word.
module tb_inst_cache_fill;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] outInst;
    logic        hit;
    logic        flush;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memReady;
    logic [31:0] memData;
    logic [15:0] missCount;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    assign memData = memAddr + 32'h100;

    inst_cache_fill dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .outInst   (outInst),
        .hit       (hit),
        .flush     (flush),
        .memReq    (memReq),
        .memAddr   (memAddr),
        .memReady  (memReady),
        .memData   (memData),
        .missCount (missCount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs from the miss-detect cycle until hit, checking every refill address on the way.
    task automatic do_fill(input logic [31:0] base, input int period, input int exp_cycles);
        int k = 0;
        int n = 0;
        bit done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            memReady = ((cyc % period) == period - 1);
            #1;
            if (hit) begin
                done = 1'b1;
            end else begin
                if (cyc == 0) check("miss_inst_zero", outInst, 32'h0);
                if (memReq) begin
                    check("fill_addr", memAddr, base + 32'(4 * k));
                    if (memReady) k++;
                end
                n++;
                tick();
            end
        end
        memReady = 1'b0;
        check("fill_done", {31'b0, done}, 32'h1);
        check("fill_words", k, 4);
        check("miss_cycles", n, exp_cycles);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b0;
        address  = 32'h0;
        flush    = 1'b0;
        memReady = 1'b0;
        #2;
        check("rst_hit", {31'b0, hit}, 32'h0);
        check("rst_inst", outInst, 32'h0);
        check("rst_req", {31'b0, memReq}, 32'h0);
        check("rst_addr", memAddr, 32'h0);
        check("rst_cnt", {16'h0, missCount}, 32'h0);
        #10;
        reset = 1'b1;

        // Cold miss on line 0 with memReady tied high.
        do_fill(32'h0, 1, 6);
        check("first_inst", outInst, 32'h100);
        check("first_cnt", {16'h0, missCount}, 32'h1);

        for (int i = 1; i < 4; i++) begin
            address = 32'(4 * i);
            #1;
            check("line0_hit", {31'b0, hit}, 32'h1);
            check("line0_inst", outInst, 32'h100 + 32'(4 * i));
            check("line0_noreq", {31'b0, memReq}, 32'h0);
            tick();
        end
        check("line0_cnt", {16'h0, missCount}, 32'h1);

        // Conflict misses on index 0.
        address = 32'h100;
        do_fill(32'h100, 1, 6);
        check("conf_inst", outInst, 32'h200);
        address = 32'h0;
        do_fill(32'h0, 1, 6);
        check("conf_back_inst", outInst, 32'h100);
        check("conf_cnt", {16'h0, missCount}, 32'h3);

        // Slow memory: strobe every 3rd cycle, line 1.
        address = 32'h14;
        do_fill(32'h10, 3, 13);
        check("slow_inst", outInst, 32'h114);
        for (int i = 0; i < 4; i++) begin
            address = 32'h10 + 32'(4 * i);
            #1;
            check("slow_line_inst", outInst, 32'h110 + 32'(4 * i));
            tick();
        end
        check("slow_cnt", {16'h0, missCount}, 32'h4);

        // Flush while the second word of a refill of address 0 is in flight.
        address = 32'h100;
        do_fill(32'h100, 1, 6);
        address  = 32'h0;
        memReady = 1'b1;
        #1;
        check("fl_detect_hit", {31'b0, hit}, 32'h0);
        tick();
        check("fl_w0_addr", memAddr, 32'h0);
        tick();
        flush = 1'b1;
        #1;
        check("fl_w1_addr", memAddr, 32'h4);
        check("fl_w1_hit", {31'b0, hit}, 32'h0);
        tick();
        flush = 1'b0;
        check("fl_w2_req", {31'b0, memReq}, 32'h1);
        check("fl_w2_addr", memAddr, 32'h8);
        tick();
        tick();
        check("fl_commit_req", {31'b0, memReq}, 32'h0);
        tick();
        memReady = 1'b0;
        check("fl_after_hit", {31'b0, hit}, 32'h0);
        do_fill(32'h0, 1, 6);
        check("fl_refill_inst", outInst, 32'h100);
        address = 32'h14;
        #1;
        check("fl_line1_hit", {31'b0, hit}, 32'h0);
        do_fill(32'h10, 1, 6);
        check("fl_line1_inst", outInst, 32'h114);
        check("fl_cnt", {16'h0, missCount}, 32'h8);

        // Asynchronous reset in the middle of a refill.
        address  = 32'h20;
        memReady = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_req", {31'b0, memReq}, 32'h0);
        check("mid_rst_hit", {31'b0, hit}, 32'h0);
        check("mid_rst_cnt", {16'h0, missCount}, 32'h0);
        check("mid_rst_addr", memAddr, 32'h0);
        #1;
        reset    = 1'b1;
        memReady = 1'b0;
        do_fill(32'h20, 1, 6);
        check("post_rst_inst", outInst, 32'h120);
        check("post_rst_cnt", {16'h0, missCount}, 32'h1);
        address = 32'h0;
        #1;
        check("post_rst_line0", {31'b0, hit}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
